barrel_shift_pipe: RTL and testbench

Parametrised, pipelined barrel shifter for the datapath's ALU shift path, built as a chain of per-bit 2:1 multiplexer stages with one register between stages. It accepts one operation per cycle under a valid/ready handshake. It supports logical left, logical right and arithmetic right shifts, plus optional rotate-right. Results appear a fixed number of cycles later, and output backpressure stalls the whole pipeline.

---
 rtl/shift_pkg.sv | 19 +
 rtl/shift_stage.sv | 49 ++++
 rtl/barrel_shift_pipe.sv | 131 +++++++++++++
 tb/tb_barrel_shift_pipe.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// -----------------------------------------------------------------------------
// shift_pkg
// Shared definitions for the pipelined barrel shifter.
//   shift_mode_e : 2-bit operation field (SLL / SRL / SRA / ROR)
//   SHIFT_MODE_W : width of the mode field
// Optional feature macro: BARREL_SHIFT_ROR_EN (see shift_stage / barrel_shift_pipe)
// -----------------------------------------------------------------------------
package shift_pkg;

    localparam int SHIFT_MODE_W = 2;

    typedef enum logic [SHIFT_MODE_W-1:0] {
        SHIFT_SLL = 2'b00,
        SHIFT_SRL = 2'b01,
        SHIFT_SRA = 2'b10,
        SHIFT_ROR = 2'b11
    } shift_mode_e;

endpackage

// File: rtl/shift_stage.sv
// -----------------------------------------------------------------------------
// shift_stage
// Combinational logic of one barrel-shifter stage: a per-bit 2:1 mux that
// either passes the operand through or shifts it by a fixed distance DIST.
// Ports:
//   data_i : operand entering the stage
//   en_i   : amount bit for this stage (1 = shift by DIST)
//   mode_i : SLL / SRL / SRA / ROR
//   sign_i : sign bit captured when the operation entered the pipeline
//   data_o : operand leaving the stage
// Macro BARREL_SHIFT_ROR_EN: when defined, ROR wraps LSBs back into the MSBs;
// when undefined, the wrap path is not built and ROR behaves as SRL.
// -----------------------------------------------------------------------------
module shift_stage
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             en_i,
    input  shift_mode_e      mode_i,
    input  logic             sign_i,
    output logic [WIDTH-1:0] data_o
);

    // Select shifted or pass-through operand for this stage
    always_comb begin
        data_o = data_i;
        if (en_i) begin
            case (mode_i)
                SHIFT_SLL: data_o = {data_i[WIDTH-DIST-1:0], {DIST{1'b0}}};
                SHIFT_SRL: data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
                // The captured sign, not the current MSB, feeds the fill so
                // every stage agrees on the original operand's sign.
                SHIFT_SRA: data_o = {{DIST{sign_i}}, data_i[WIDTH-1:DIST]};
`ifdef BARREL_SHIFT_ROR_EN
                SHIFT_ROR: data_o = {data_i[DIST-1:0], data_i[WIDTH-1:DIST]};
`else
                SHIFT_ROR: data_o = {{DIST{1'b0}}, data_i[WIDTH-1:DIST]};
`endif
                default:   data_o = data_i;
            endcase
        end else begin
            data_o = data_i;
        end
    end

endmodule

// File: rtl/barrel_shift_pipe.sv
// -----------------------------------------------------------------------------
// barrel_shift_pipe
// Pipelined barrel shifter: an entry register followed by SHW shift stages,
// each stage registered. An op accepted at edge N is on the output after
// edge N+SHW. A single advance signal moves or freezes the whole pipeline.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   in_valid/in_ready   : input handshake (in_ready = !out_valid || out_ready)
//   in_data, in_amt     : operand and shift amount (0..WIDTH-1)
//   in_mode             : 00 SLL, 01 SRL, 10 SRA, 11 ROR
//   out_valid/out_ready : output handshake
//   out_data            : registered shifted result
//   out_zero            : out_data == 0, decoded from the output register
// Macro BARREL_SHIFT_ROR_EN: enables rotate-right for mode 11 (else SRL).
// -----------------------------------------------------------------------------
module barrel_shift_pipe
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero
);

    // Slot 0 is the entry register; slot k+1 holds the result of stage k.
    // Slot SHW is the output register and carries only valid + data.
    logic             valid_q [0:SHW];
    logic             valid_d [0:SHW];
    logic [WIDTH-1:0] data_q  [0:SHW];
    logic [WIDTH-1:0] data_d  [0:SHW];
    logic [SHW-1:0]   amt_q   [0:SHW-1];
    logic [SHW-1:0]   amt_d   [0:SHW-1];
    shift_mode_e      mode_q  [0:SHW-1];
    shift_mode_e      mode_d  [0:SHW-1];
    logic             sign_q  [0:SHW-1];
    logic             sign_d  [0:SHW-1];

    logic [WIDTH-1:0] stage_data_s [0:SHW-1];
    logic             adv_s;

    // Whole pipeline advances unless a valid result is blocked at the output
    assign adv_s     = !valid_q[SHW] || out_ready;
    assign in_ready  = adv_s;
    assign out_valid = valid_q[SHW];
    assign out_data  = data_q[SHW];
    assign out_zero  = (data_q[SHW] == {WIDTH{1'b0}});

    genvar k;
    generate
        for (k = 0; k < SHW; k++) begin : g_stage
            shift_stage #(
                .WIDTH (WIDTH),
                .DIST  (1 << k)
            ) u_stage (
                .data_i (data_q[k]),
                .en_i   (amt_q[k][k]),
                .mode_i (mode_q[k]),
                .sign_i (sign_q[k]),
                .data_o (stage_data_s[k])
            );
        end
    endgenerate

    // Next-state: load every slot from its predecessor on advance, else hold
    always_comb begin
        for (int i = 0; i <= SHW; i++) begin
            valid_d[i] = valid_q[i];
            data_d[i]  = data_q[i];
        end
        for (int i = 0; i < SHW; i++) begin
            amt_d[i]  = amt_q[i];
            mode_d[i] = mode_q[i];
            sign_d[i] = sign_q[i];
        end
        if (adv_s) begin
            valid_d[0] = in_valid;
            data_d[0]  = in_data;
            amt_d[0]   = in_amt;
            mode_d[0]  = shift_mode_e'(in_mode);
            sign_d[0]  = in_data[WIDTH-1];
            for (int i = 0; i < SHW; i++) begin
                valid_d[i+1] = valid_q[i];
                data_d[i+1]  = stage_data_s[i];
            end
            for (int i = 1; i < SHW; i++) begin
                amt_d[i]  = amt_q[i-1];
                mode_d[i] = mode_q[i-1];
                sign_d[i] = sign_q[i-1];
            end
        end else begin
            // Stall: the defaults above already hold every slot, bubbles included
            valid_d[0] = valid_q[0];
        end
    end

    // Pipeline registers with asynchronous clear of all in-flight state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= SHW; i++) begin
                valid_q[i] <= 1'b0;
                data_q[i]  <= {WIDTH{1'b0}};
            end
            for (int i = 0; i < SHW; i++) begin
                amt_q[i]  <= {SHW{1'b0}};
                mode_q[i] <= SHIFT_SLL;
                sign_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i <= SHW; i++) begin
                valid_q[i] <= valid_d[i];
                data_q[i]  <= data_d[i];
            end
            for (int i = 0; i < SHW; i++) begin
                amt_q[i]  <= amt_d[i];
                mode_q[i] <= mode_d[i];
                sign_q[i] <= sign_d[i];
            end
        end
    end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// -----------------------------------------------------------------------------
// tb_barrel_shift_pipe
// Self-checking bench: directed scenarios followed by a randomised sweep,
// compared against a behavioural shift model and an in-order result queue.
// -----------------------------------------------------------------------------
module tb_barrel_shift_pipe;

    localparam int W   = 32;
    localparam int SHW = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   in_data;
    logic [SHW-1:0] in_amt;
    logic [1:0]     in_mode;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic           out_zero;

    barrel_shift_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic last_acc = 1'b0;

    // Timing model: a delay line of SHW+1 slots that advances like the spec says
    logic         pv [0:SHW];
    logic [W-1:0] pd [0:SHW];

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];
    int           got_cyc[$];
    int           acc_cyc[$];

    // Reference shift, from the arithmetic meaning of each mode
    function automatic logic [W-1:0] ref_shift(input logic [W-1:0] d, input int a,
                                               input logic [1:0] m);
        logic [2*W-1:0] dd;
        logic [W-1:0]   r;
        case (m)
            2'b00:   r = d << a;
            2'b01:   r = d >> a;
            2'b10:   r = $signed(d) >>> a;
`ifdef BARREL_SHIFT_ROR_EN
            default: begin dd = {d, d} >> a; r = dd[W-1:0]; end
`else
            default: begin dd = {{W{1'b0}}, d} >> a; r = dd[W-1:0]; end
`endif
        endcase
        return r;
    endfunction

    task automatic chkw(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i <= SHW; i++) begin
            pv[i] = 1'b0;
            pd[i] = '0;
        end
        exp_q.delete();
    endtask

    // One clock: check outputs at negedge, track transfers, advance model at posedge
    task automatic tick();
        logic acc;
        logic [W-1:0] e;
        @(negedge clk);
        chk1("out_valid", out_valid, pv[SHW]);
        chk1("in_ready", in_ready, !pv[SHW] || out_ready);
        if (pv[SHW]) begin
            chkw("out_data", out_data, pd[SHW]);
            chk1("out_zero", out_zero, pd[SHW] == '0);
        end
        if (out_valid && out_ready && !rst) begin
            got_q.push_back(out_data);
            got_cyc.push_back(cyc);
            chk1("out_expected", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chkw("order", out_data, e);
            end
        end
        acc = in_valid && (!pv[SHW] || out_ready) && !rst;
        last_acc = acc;
        if (acc) begin
            exp_q.push_back(ref_shift(in_data, int'(in_amt), in_mode));
            acc_cyc.push_back(cyc);
        end
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (!pv[SHW] || out_ready) begin
            for (int i = SHW; i > 0; i--) begin
                pv[i] = pv[i-1];
                pd[i] = pd[i-1];
            end
            pv[0] = in_valid;
            pd[0] = ref_shift(in_data, int'(in_amt), in_mode);
        end
        cyc++;
        #1;
    endtask

    task automatic put(input logic [W-1:0] d, input int a, input logic [1:0] m);
        in_valid = 1'b1;
        in_data  = d;
        in_amt   = SHW'(a);
        in_mode  = m;
        tick();
    endtask

    task automatic clear_logs();
        got_q.delete();
        got_cyc.delete();
        acc_cyc.delete();
    endtask

    logic [W-1:0]   hold;
    logic [W-1:0]   sd [0:7];
    logic [SHW-1:0] sa [0:7];
    logic [1:0]     sm [0:7];
    int idx;
    int stall_left;
    int nacc;

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_amt = '0; in_mode = 2'b00;
        out_ready = 1'b1;
        model_clear();

        // Reset state
        #1;
        chk1("rst_out_valid", out_valid, 1'b0);
        chk1("rst_in_ready", in_ready, 1'b1);
        chk1("rst_out_zero", out_zero, 1'b1);
        tick(); tick();
        rst = 1'b0;
        repeat (8) tick();   // nothing accepted: out_valid must stay low

        // Basic modes, back to back
        clear_logs();
        put(32'h0000_00F1, 4, 2'b00);
        put(32'h8000_0000, 31, 2'b01);
        put(32'h8000_0000, 4, 2'b10);
        in_valid = 1'b0;
        repeat (8) tick();
        chkw("basic_count", W'(got_q.size()), 32'd3);
        if (got_q.size() == 3) begin
            chkw("sll", got_q[0], 32'h0000_0F10);
            chkw("srl", got_q[1], 32'h0000_0001);
            chkw("sra", got_q[2], 32'hF800_0000);
            for (int i = 0; i < 3; i++)
                chkw("latency", W'(got_cyc[i] - acc_cyc[i] - 1), 32'd5);
            chkw("consecutive", W'(got_cyc[2] - got_cyc[0]), 32'd2);
        end

        // ROR / zero flag and amount 0 in all modes
        clear_logs();
        put(32'h0000_0001, 1, 2'b11);
        for (int m = 0; m < 4; m++) put(32'hA5A5_1234, 0, 2'(m));
        in_valid = 1'b0;
        repeat (8) tick();
        chkw("ror_count", W'(got_q.size()), 32'd5);
        if (got_q.size() == 5) begin
`ifdef BARREL_SHIFT_ROR_EN
            chkw("ror", got_q[0], 32'h8000_0000);
`else
            chkw("ror_as_srl", got_q[0], 32'h0000_0000);
`endif
            for (int i = 1; i < 5; i++) chkw("amt0", got_q[i], 32'hA5A5_1234);
        end

        // Backpressure: 8 ops, 3-cycle stall once output is valid
        clear_logs();
        for (int i = 0; i < 8; i++) begin
            sd[i] = $urandom; sa[i] = SHW'($urandom_range(0, W-1)); sm[i] = 2'($urandom_range(0, 3));
        end
        idx = 0; stall_left = 3;
        for (int c = 0; c < 80 && got_q.size() < 8; c++) begin
            if (out_valid && stall_left > 0) begin
                out_ready = 1'b0;
                #1;
                chk1("stall_in_ready", in_ready, 1'b0);
                if (stall_left < 3) chkw("stall_hold", out_data, hold);
                hold = out_data;
                stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            in_valid = (idx < 8);
            if (idx < 8) begin
                in_data = sd[idx]; in_amt = sa[idx]; in_mode = sm[idx];
            end
            tick();
            if (last_acc) idx++;
        end
        out_ready = 1'b1; in_valid = 1'b0;
        chkw("bp_count", W'(got_q.size()), 32'd8);
        chkw("bp_stalled", W'(stall_left), 32'd0);
        if (got_q.size() == 8)
            for (int i = 0; i < 8; i++)
                chkw("bp_data", got_q[i], ref_shift(sd[i], int'(sa[i]), sm[i]));

        // Reset mid-flight
        clear_logs();
        put(32'h1234_5678, 3, 2'b00);
        put(32'h8765_4321, 7, 2'b10);
        put(32'hFFFF_0000, 9, 2'b01);
        in_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk1("rst_async", out_valid, 1'b0);
        model_clear();
        tick();
        rst = 1'b0;
        repeat (12) tick();
        chkw("rst_flush", W'(got_q.size()), 32'd0);

        // Randomised sweep
        clear_logs();
        nacc = 0;
        in_valid = 1'b0;
        last_acc = 1'b0;
        for (int c = 0; c < 6000 && nacc < 1000; c++) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                in_data  = $urandom;
                in_amt   = SHW'($urandom_range(0, W-1));
                in_mode  = 2'($urandom_range(0, 3));
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            if (last_acc) nacc++;
        end
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (10) tick();
        chkw("rand_accepted", W'(nacc), 32'd1000);
        chkw("rand_drained", W'(exp_q.size()), 32'd0);
        chkw("rand_delivered", W'(got_q.size()), W'(nacc));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
